// File: rtl/register_bank_pkg.sv
// Shared encodings for the datapath register bank: register indices,
// B_Bus select codes and the memory-read FSM states.
package register_bank_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int NUM_REGS   = 10;

    // wr_en bit positions, also used as register-array indices
    localparam int WR_PC = 0;
    localparam int WR_AR = 1;
    localparam int WR_DR = 2;
    localparam int WR_IR = 3;
    localparam int WR_R1 = 4;
    localparam int WR_R2 = 5;
    localparam int WR_R3 = 6;
    localparam int WR_R4 = 7;
    localparam int WR_TR = 8;
    localparam int WR_AC = 9;

    localparam logic [3:0] BSEL_ZERO = 4'd0;
    localparam logic [3:0] BSEL_PC   = 4'd1;
    localparam logic [3:0] BSEL_AR   = 4'd2;
    localparam logic [3:0] BSEL_DR   = 4'd3;
    localparam logic [3:0] BSEL_IR   = 4'd4;
    localparam logic [3:0] BSEL_R1   = 4'd5;
    localparam logic [3:0] BSEL_R2   = 4'd6;
    localparam logic [3:0] BSEL_R3   = 4'd7;
    localparam logic [3:0] BSEL_R4   = 4'd8;
    localparam logic [3:0] BSEL_TR   = 4'd9;
    localparam logic [3:0] BSEL_AC   = 4'd10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

endpackage

// File: rtl/register_bank_mem_read_ctrl.sv
// Two-state memory read handshake: holds the request until ack and strobes
// the DR load on the ack cycle.
module mem_read_ctrl
    import register_bank_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    input  logic i_ack,
    output logic o_req,
    output logic o_busy,
    output logic o_dr_valid,
    output logic o_dr_load
);

    mem_state_e r_state;
    mem_state_e w_next;
    logic       r_dr_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_dr_valid <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_dr_valid <= o_dr_load;
        end
    end

    // A start request while already waiting is deliberately dropped.
    always_comb begin
        w_next    = r_state;
        o_dr_load = 1'b0;
        case (r_state)
            ST_IDLE: if (i_start) w_next = ST_WAIT;
            ST_WAIT: begin
                if (i_ack) begin
                    w_next    = ST_IDLE;
                    o_dr_load = 1'b1;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // The state is a single flop, so the request is glitch-free.
    assign o_req      = (r_state == ST_WAIT);
    assign o_busy     = (r_state == ST_WAIT);
    assign o_dr_valid = r_dr_valid;

endmodule

// File: rtl/register_bank.sv
// Architectural register bank: drives the ALU operand buses, writes back
// C_Bus, and fills DR through the memory read handshake.
module register_bank
    import register_bank_pkg::*;
#(
    parameter int               DATA_W = DATA_W_DEF,
    parameter logic [DATA_W-1:0] AC_RST = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] c_bus,
    input  logic [9:0]        wr_en,
    input  logic [1:0]        inc_en,
    input  logic [3:0]        b_sel,
    input  logic              mem_rd_start,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] a_bus,
    output logic [DATA_W-1:0] b_bus,
    output logic              mem_req,
    output logic [DATA_W-1:0] mem_addr,
    output logic              busy,
    output logic              dr_valid,
    output logic              z_flag,
    output logic [DATA_W-1:0] pc_out,
    output logic [DATA_W-1:0] ir_out
);

    localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic              r_z;
    logic              w_dr_load;

    mem_read_ctrl u_mem_read_ctrl (
        .clk        (clk),
        .rst        (rst),
        .i_start    (mem_rd_start),
        .i_ack      (mem_ack),
        .o_req      (mem_req),
        .o_busy     (busy),
        .o_dr_valid (dr_valid),
        .o_dr_load  (w_dr_load)
    );

    // Later assignments take priority: increment < C_Bus write < memory data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                r_regs[i] <= (i == WR_AC) ? AC_RST : '0;
            r_z <= (AC_RST == '0);
        end else begin
            if (inc_en[0]) r_regs[WR_PC] <= r_regs[WR_PC] + ONE;
            if (inc_en[1]) r_regs[WR_AR] <= r_regs[WR_AR] + ONE;
            for (int i = 0; i < NUM_REGS; i++)
                if (wr_en[i]) r_regs[i] <= c_bus;
            if (w_dr_load) r_regs[WR_DR] <= mem_rdata;
            if (wr_en[WR_AC]) r_z <= (c_bus == '0);
        end
    end

    always_comb begin
        b_bus = '0;
        case (b_sel)
            BSEL_PC: b_bus = r_regs[WR_PC];
            BSEL_AR: b_bus = r_regs[WR_AR];
            BSEL_DR: b_bus = r_regs[WR_DR];
            BSEL_IR: b_bus = r_regs[WR_IR];
            BSEL_R1: b_bus = r_regs[WR_R1];
            BSEL_R2: b_bus = r_regs[WR_R2];
            BSEL_R3: b_bus = r_regs[WR_R3];
            BSEL_R4: b_bus = r_regs[WR_R4];
            BSEL_TR: b_bus = r_regs[WR_TR];
            BSEL_AC: b_bus = r_regs[WR_AC];
            default: b_bus = '0;
        endcase
    end

    assign a_bus    = r_regs[WR_AC];
    assign mem_addr = r_regs[WR_AR];
    assign pc_out   = r_regs[WR_PC];
    assign ir_out   = r_regs[WR_IR];
    assign z_flag   = r_z;

endmodule

// File: tb/tb_register_bank.sv
// Directed bench for register_bank: a behavioural register/memory model is
// compared every cycle, plus literal expectations at key points.
module tb_register_bank;

    logic        clk;
    logic        rst;
    logic [15:0] c_bus;
    logic [9:0]  wr_en;
    logic [1:0]  inc_en;
    logic [3:0]  b_sel;
    logic        mem_rd_start;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] a_bus, b_bus, mem_addr, pc_out, ir_out;
    logic        mem_req, busy, dr_valid, z_flag;

    int n_checks = 0;
    int n_errors = 0;

    register_bank dut (
        .clk(clk), .rst(rst), .c_bus(c_bus), .wr_en(wr_en), .inc_en(inc_en),
        .b_sel(b_sel), .mem_rd_start(mem_rd_start), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .a_bus(a_bus), .b_bus(b_bus), .mem_req(mem_req),
        .mem_addr(mem_addr), .busy(busy), .dr_valid(dr_valid), .z_flag(z_flag),
        .pc_out(pc_out), .ir_out(ir_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: index k holds the register selected by b_sel k+1 (PC..AC).
    logic [15:0] m_reg [10];
    logic        m_z, m_pend, m_dv;

    always @(posedge clk or posedge rst) begin : model
        logic [15:0] nx [10];
        if (rst) begin
            for (int i = 0; i < 10; i++) m_reg[i] <= 16'h0000;
            m_z    <= 1'b1;
            m_pend <= 1'b0;
            m_dv   <= 1'b0;
        end else begin
            nx = m_reg;
            if (inc_en[0]) nx[0] = 16'((32'(m_reg[0]) + 1) % 65536);
            if (inc_en[1]) nx[1] = 16'((32'(m_reg[1]) + 1) % 65536);
            for (int i = 0; i < 10; i++) if (wr_en[i]) nx[i] = c_bus;
            m_dv <= 1'b0;
            if (m_pend && mem_ack) begin
                nx[2]  = mem_rdata;
                m_pend <= 1'b0;
                m_dv   <= 1'b1;
            end else if (!m_pend && mem_rd_start) begin
                m_pend <= 1'b1;
            end
            if (wr_en[9]) m_z <= (c_bus == 16'h0000);
            m_reg <= nx;
        end
    end

    always @(negedge clk) begin : compare
        logic [15:0] exp_b;
        int s;
        s = int'(b_sel);
        exp_b = (s >= 1 && s <= 10) ? m_reg[s-1] : 16'h0000;
        chk("m_b_bus",    b_bus,    exp_b);
        chk("m_a_bus",    a_bus,    m_reg[9]);
        chk("m_pc_out",   pc_out,   m_reg[0]);
        chk("m_ir_out",   ir_out,   m_reg[3]);
        chk("m_mem_addr", mem_addr, m_reg[1]);
        chk("m_mem_req",  16'(mem_req),  16'(m_pend));
        chk("m_busy",     16'(busy),     16'(m_pend));
        chk("m_dr_valid", 16'(dr_valid), 16'(m_dv));
        chk("m_z_flag",   16'(z_flag),   16'(m_z));
    end

    task automatic step(input logic [9:0] wr, input logic [1:0] inc, input logic [3:0] bs,
                        input logic [15:0] cb, input logic st, input logic ak,
                        input logic [15:0] rd);
        @(negedge clk);
        #1;
        wr_en = wr; inc_en = inc; b_sel = bs; c_bus = cb;
        mem_rd_start = st; mem_ack = ak; mem_rdata = rd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        c_bus = '0; wr_en = '0; inc_en = '0; b_sel = '0;
        mem_rd_start = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        #1 rst = 1'b1;

        for (int b = 1; b <= 10; b++) begin
            b_sel = 4'(b);
            #1 chk("rst_b_bus", b_bus, 16'h0000);
        end
        chk("rst_a_bus",   a_bus, 16'h0000);
        chk("rst_z_flag",  16'(z_flag), 16'h0001);
        chk("rst_mem_req", 16'(mem_req), 16'h0000);
        chk("rst_busy",    16'(busy), 16'h0000);
        @(negedge clk); #1 rst = 1'b0;

        step(10'h010, 2'b00, 4'd5, 16'h1234, 0, 0, 0);
        chk("r1_write", b_bus, 16'h1234);
        chk("r1_pc_untouched", pc_out, 16'h0000);
        chk("r1_ac_untouched", a_bus, 16'h0000);

        step(10'h001, 2'b00, 4'd1, 16'hFFFF, 0, 0, 0);
        chk("pc_load", pc_out, 16'hFFFF);
        step(10'h000, 2'b01, 4'd1, 16'h0000, 0, 0, 0);
        chk("pc_wrap", pc_out, 16'h0000);
        step(10'h001, 2'b01, 4'd1, 16'h0042, 0, 0, 0);
        chk("pc_wr_beats_inc", pc_out, 16'h0042);
        step(10'h000, 2'b11, 4'd1, 16'h0000, 0, 0, 0);
        chk("pc_inc", pc_out, 16'h0043);

        step(10'h002, 2'b00, 4'd2, 16'hFFFF, 0, 0, 0);
        step(10'h000, 2'b10, 4'd2, 16'h0000, 0, 0, 0);
        chk("ar_wrap", b_bus, 16'h0000);

        step(10'h200, 2'b00, 4'd10, 16'h0000, 0, 0, 0);
        chk("z_set", 16'(z_flag), 16'h0001);
        step(10'h200, 2'b00, 4'd10, 16'h0005, 0, 0, 0);
        chk("z_clr", 16'(z_flag), 16'h0000);
        chk("ac_load", a_bus, 16'h0005);
        step(10'h010, 2'b00, 4'd5, 16'h0000, 0, 0, 0);
        chk("z_hold", 16'(z_flag), 16'h0000);

        step(10'h3F0, 2'b00, 4'd9, 16'hABCD, 0, 0, 0);
        chk("multi_tr", b_bus, 16'hABCD);
        chk("multi_ac", a_bus, 16'hABCD);
        step(10'h008, 2'b00, 4'd7, 16'hC0DE, 0, 0, 0);
        chk("ir_load", ir_out, 16'hC0DE);
        chk("multi_r3", b_bus, 16'hABCD);
        step(10'h000, 2'b00, 4'd12, 16'h0000, 0, 0, 0);
        chk("bsel_12_zero", b_bus, 16'h0000);

        step(10'h000, 2'b00, 4'd3, 16'h0000, 0, 1, 16'h5555);
        chk("idle_ack_ignored", b_bus, 16'h0000);

        step(10'h002, 2'b00, 4'd2, 16'h0100, 0, 0, 0);
        step(10'h000, 2'b00, 4'd3, 16'h0000, 1, 0, 0);
        chk("rd_req", 16'(mem_req), 16'h0001);
        chk("rd_busy", 16'(busy), 16'h0001);
        chk("rd_addr", mem_addr, 16'h0100);
        step(10'h000, 2'b00, 4'd3, 16'h0000, 1, 0, 0);
        chk("rd_restart_held", 16'(mem_req), 16'h0001);
        step(10'h000, 2'b00, 4'd3, 16'h0000, 0, 0, 0);
        step(10'h000, 2'b00, 4'd3, 16'h0000, 0, 1, 16'hBEEF);
        chk("rd_dr", b_bus, 16'hBEEF);
        chk("rd_valid", 16'(dr_valid), 16'h0001);
        chk("rd_busy_low", 16'(busy), 16'h0000);
        chk("rd_req_low", 16'(mem_req), 16'h0000);
        step(10'h000, 2'b00, 4'd3, 16'h0000, 0, 0, 0);
        chk("rd_valid_pulse", 16'(dr_valid), 16'h0000);
        chk("rd_no_extra_req", 16'(mem_req), 16'h0000);

        step(10'h000, 2'b00, 4'd3, 16'h0000, 1, 0, 0);
        step(10'h004, 2'b00, 4'd3, 16'h1111, 0, 1, 16'h2222);
        chk("dr_mem_wins", b_bus, 16'h2222);

        step(10'h000, 2'b00, 4'd3, 16'h0000, 1, 0, 0);
        step(10'h002, 2'b00, 4'd3, 16'h0200, 0, 0, 0);
        chk("ar_move_in_wait", mem_addr, 16'h0200);
        chk("wait_req_held", 16'(mem_req), 16'h0001);

        @(negedge clk);
        #2;
        wr_en = '0; inc_en = '0; c_bus = '0; b_sel = 4'd3;
        mem_rd_start = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        rst = 1'b1;
        #1;
        chk("rst_wait_req", 16'(mem_req), 16'h0000);
        chk("rst_wait_busy", 16'(busy), 16'h0000);
        chk("rst_wait_dr", b_bus, 16'h0000);
        @(negedge clk); #1 rst = 1'b0;

        step(10'h000, 2'b00, 4'd3, 16'h0000, 0, 1, 16'hDEAD);
        chk("stray_ack_dr", b_bus, 16'h0000);
        chk("stray_ack_valid", 16'(dr_valid), 16'h0000);
        step(10'h000, 2'b00, 4'd0, 16'h0000, 0, 0, 0);
        @(negedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
